// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = $clog2(WORD_BYTES);
    localparam int CNT_W      = 4;

    // Error codes carried on err_o.
    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_ADDR = 1'b1;   // misaligned or beyond the backing array

    // Flags a byte address that is not word aligned or falls past the last word.
    function automatic logic addr_check(input logic [31:0] addr, input int unsigned depth_words);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[ADDR_LSB-1:0] != '0);
        out_of_range = ((addr >> ADDR_LSB) >= depth_words);
        return (misaligned || out_of_range) ? ERR_ADDR : ERR_NONE;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory port between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;

    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        stall_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ready_o, ack_o, rdata_o, err_o, stall_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ready_o, ack_o, rdata_o, err_o, stall_o
    );

endinterface

// File: rtl/dmem_sram_1rw.sv
// Single-port synchronous word array with a registered read port.
// A write leaves rdata untouched, so the last load result stays on the output.
module dmem_sram_1rw #(
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] index,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Synchronous write or registered read of one word.
    // NOTE: the array and its read register have no reset; a RAM macro cannot be
    // cleared in one cycle, and the controller never exposes rdata before a load.
    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) begin
                mem[index] <= wdata;
            end else begin
                rdata <= mem[index];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one outstanding load/store,
// fixed LATENCY from acceptance to a one-cycle acknowledge.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dmem_responder_if.slave bus
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    // Configuration guards, evaluated at elaboration.
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be within 1..15");
    end
    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be a power of two >= 4");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             fire;

    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             err_q;
    logic             rd_valid_q;
    logic             addr_bad;

    logic             sram_en;
    logic [31:0]      sram_rdata;

    assign addr_bad = addr_check(addr_q, DEPTH_WORDS);

    // State register and down-counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; fire marks the edge that completes the access.
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    fire    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the request at acceptance; later bus activity is ignored until idle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.we_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.wdata_i;
        end
    end

    // Response flags: error code, and whether rdata_o shows array data or zero.
    // A clean store leaves rd_valid_q alone so the previous load result is held.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q      <= ERR_NONE;
            rd_valid_q <= 1'b0;
        end else if (fire) begin
            err_q <= addr_bad;
            if (addr_bad) begin
                rd_valid_q <= 1'b0;
            end else if (!we_q) begin
                rd_valid_q <= 1'b1;
            end
        end
    end

    // The array is touched only on the completing edge of a legal access, so a
    // reset during BUSY drops the request without a write.
    assign sram_en = fire & ~addr_bad;

    dmem_sram_1rw #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk_i (clk_i),
        .en    (sram_en),
        .we    (we_q),
        .index (addr_q[ADDR_LSB +: IDX_W]),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

    logic ack;
    assign ack         = (state_q == RESP);
    assign bus.ack_o   = ack;
    assign bus.ready_o = (state_q == IDLE);
    assign bus.err_o   = ack & err_q;
    assign bus.rdata_o = rd_valid_q ? sram_rdata : '0;
    assign bus.stall_o = bus.req_i & ~ack;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: requests push expected responses,
// a monitor pops and compares on every acknowledge.
module tb_dmem_responder;

    localparam int LAT_A = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT_A)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_a.slave)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_b (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_b.slave)
    );

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        bit          chk_rdata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every acknowledge from the latency-3 responder consumes one expectation.
    always @(negedge clk) begin
        if (rst_n && bus_a.ack_o) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(bus_a.ack_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_err"}, 32'(bus_a.err_o), 32'(e.err));
                if (e.chk_rdata) begin
                    check({e.name, "_rdata"}, bus_a.rdata_o, e.rdata);
                end
            end
        end
    end

    // Issue one request on bus A, hold it until acknowledged, and check the
    // handshake timing; disturb=1 wiggles the inputs while the responder is busy.
    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [31:0] exp_rdata, input bit chk_rd, input bit disturb);
        int   wait_cnt;
        int   lat;
        int   rdy_lo;
        bit   got;
        logic req_now;
        sb.push_back('{name, exp_err, exp_rdata, chk_rd});
        @(negedge clk);
        req_now       = 1'b1;
        bus_a.req_i   = req_now;
        bus_a.we_i    = we;
        bus_a.addr_i  = addr;
        bus_a.wdata_i = wdata;
        wait_cnt = 0;
        while (!bus_a.ready_o && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check({name, "_accept_wait"}, 32'(wait_cnt < 20), 32'd1);
        @(posedge clk);
        lat    = 0;
        rdy_lo = 0;
        got    = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!bus_a.ready_o) rdy_lo++;
            if (bus_a.ack_o) begin
                got = 1'b1;
                break;
            end
            check({name, "_stall_busy"}, 32'(bus_a.stall_o), 32'(req_now));
            if (disturb && lat == 0) begin
                req_now       = 1'b0;
                bus_a.addr_i  = 32'h0000_0040;
                bus_a.wdata_i = 32'hFFFF_FFFF;
                bus_a.we_i    = ~we;
            end else if (disturb && lat == 1) begin
                req_now = 1'b1;
            end
            bus_a.req_i = req_now;
            lat++;
        end
        check({name, "_ack_seen"}, 32'(got), 32'd1);
        check({name, "_latency"}, lat, LAT_A);
        check({name, "_ready_low"}, rdy_lo, LAT_A + 1);
        check({name, "_stall_ack"}, 32'(bus_a.stall_o), 32'd0);
        bus_a.req_i = 1'b0;
    endtask

    initial begin
        int acc0, acc1, ack0, n_ack;
        bus_a.req_i = 1'b0; bus_a.we_i = 1'b0; bus_a.addr_i = '0; bus_a.wdata_i = '0;
        bus_b.req_i = 1'b0; bus_b.we_i = 1'b0; bus_b.addr_i = '0; bus_b.wdata_i = '0;

        // Reset values.
        #12;
        check("rst_ready", 32'(bus_a.ready_o), 32'd1);
        check("rst_ack",   32'(bus_a.ack_o),   32'd0);
        check("rst_err",   32'(bus_a.err_o),   32'd0);
        check("rst_rdata", bus_a.rdata_o,      32'd0);
        check("rst_stall", 32'(bus_a.stall_o), 32'd0);
        check("rst_ready_b", 32'(bus_b.ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed responses.
        do_req("st_10",  1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          1'b0, 1'b0);
        do_req("ld_10",  1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        do_req("st_13",  1'b1, 32'h0000_0013, 32'h5555_5555, 1'b1, 32'h0,          1'b0, 1'b0);
        do_req("ld_10b", 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        do_req("ld_400", 1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0,          1'b1, 1'b0);
        do_req("ld_11",  1'b0, 32'h0000_0011, 32'h0,         1'b1, 32'h0,          1'b1, 1'b0);
        do_req("st_3fc", 1'b1, 32'h0000_03FC, 32'hA5A5_0001, 1'b0, 32'h0,          1'b0, 1'b0);
        do_req("ld_3fc", 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hA5A5_0001, 1'b1, 1'b0);
        do_req("st_20",  1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1'b0, 32'h0,          1'b0, 1'b0);
        @(negedge clk);
        check("rdata_hold_after_store", bus_a.rdata_o, 32'hA5A5_0001);

        // Reset in the middle of a store: no acknowledge, no write.
        bus_a.req_i = 1'b1; bus_a.we_i = 1'b1;
        bus_a.addr_i = 32'h0000_0020; bus_a.wdata_i = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", 32'(bus_a.ready_o), 32'd0);
        bus_a.req_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus_a.ready_o), 32'd1);
        check("midrst_ack",   32'(bus_a.ack_o),   32'd0);
        check("midrst_err",   32'(bus_a.err_o),   32'd0);
        check("midrst_rdata", bus_a.rdata_o,      32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_ready", 32'(bus_a.ready_o), 32'd1);
        do_req("ld_20",  1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h0BAD_F00D, 1'b1, 1'b0);

        // Inputs changed and req pulsed while busy must not affect the access.
        do_req("st_40",  1'b1, 32'h0000_0040, 32'h1111_1111, 1'b0, 32'h0,          1'b0, 1'b0);
        do_req("st_30d", 1'b1, 32'h0000_0030, 32'hCAFE_0001, 1'b0, 32'h0,          1'b0, 1'b1);
        do_req("ld_40",  1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'h1111_1111, 1'b1, 1'b0);
        do_req("ld_30",  1'b0, 32'h0000_0030, 32'h0,         1'b0, 32'hCAFE_0001, 1'b1, 1'b0);

        // LATENCY=1 responder with req held high: accept, ack two cycles later,
        // next accept three cycles after the first.
        @(negedge clk);
        bus_b.req_i = 1'b1; bus_b.we_i = 1'b1;
        bus_b.addr_i = 32'h0000_0008; bus_b.wdata_i = 32'h0000_0077;
        acc0 = -1; acc1 = -1; ack0 = -1; n_ack = 0;
        for (int n = 0; n < 12; n++) begin
            if (bus_b.ready_o && bus_b.req_i) begin
                if (acc0 < 0) acc0 = n;
                else if (acc1 < 0) acc1 = n;
            end
            if (bus_b.ack_o) begin
                n_ack++;
                if (ack0 < 0) ack0 = n;
            end
            @(negedge clk);
        end
        bus_b.req_i = 1'b0;
        check("b_first_accept", acc0, 0);
        check("b_ack_delay",    ack0 - acc0, 2);
        check("b_reaccept",     acc1 - acc0, 3);
        check("b_ack_count",    n_ack, 4);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
